// File: rtl/carry_skip_pkg.sv
// Shared constants and helpers for the carry-skip adder.
// Optional overflow output is enabled by defining CARRY_SKIP_OVF_EN.
package carry_skip_pkg;

    localparam int CSK_WIDTH = 8;
    localparam int CSK_BLOCK = 4;

    function automatic int csk_num_blocks(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/carry_skip_block.sv
// One skip block: BLOCK-bit ripple adder plus block-propagate and skip mux.
module carry_skip_block
    import carry_skip_pkg::*;
#(
    parameter int BLOCK = CSK_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             c_ripple,
    output logic             p_blk,
    output logic             cout
);

    logic [BLOCK-1:0] w_p;
    logic [BLOCK-1:0] w_g;
    logic [BLOCK:0]   w_c;

    assign w_p    = a ^ b;
    assign w_g    = a & b;
    assign w_c[0] = cin;

    generate
        for (genvar gi = 0; gi < BLOCK; gi++) begin : g_bit
            assign sum[gi]    = w_p[gi] ^ w_c[gi];
            assign w_c[gi+1]  = w_g[gi] | (w_p[gi] & w_c[gi]);
        end
    endgenerate

    assign c_ripple = w_c[BLOCK];
    assign p_blk    = &w_p;
    // When every bit propagates, the incoming carry bypasses the ripple chain.
    assign cout     = p_blk ? cin : c_ripple;

endmodule

// File: rtl/carry_skip_adder.sv
// Registered WIDTH-bit carry-skip adder, one cycle latency.
// Define CARRY_SKIP_OVF_EN to add the registered signed-overflow output ovf.
module carry_skip_adder
    import carry_skip_pkg::*;
#(
    parameter int WIDTH = CSK_WIDTH,
    parameter int BLOCK = CSK_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef CARRY_SKIP_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NB = csk_num_blocks(WIDTH, BLOCK);

    generate
        if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
            $error("carry_skip_adder: WIDTH must be a positive multiple of BLOCK");
        end
    endgenerate

    logic [NB:0]      w_carry;
    logic [NB-1:0]    w_ripple;
    logic [NB-1:0]    w_prop;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    assign w_carry[0] = cin;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_blk
            carry_skip_block #(
                .BLOCK(BLOCK)
            ) u_blk (
                .a        (a[gi*BLOCK +: BLOCK]),
                .b        (b[gi*BLOCK +: BLOCK]),
                .cin      (w_carry[gi]),
                .sum      (w_sum[gi*BLOCK +: BLOCK]),
                .c_ripple (w_ripple[gi]),
                .p_blk    (w_prop[gi]),
                .cout     (w_carry[gi+1])
            );

            // Skip and ripple paths must agree whenever the skip is taken.
            always_comb begin
                if (w_prop[gi]) begin
                    assert (w_ripple[gi] == w_carry[gi]);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[NB];
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_valid;

`ifdef CARRY_SKIP_OVF_EN
    logic w_c_msb;
    logic r_ovf;

    // Carry into the MSB recovered from its propagate bit and sum bit.
    assign w_c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ w_sum[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_c_msb ^ w_carry[NB];
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_carry_skip_adder.sv
// Self-checking bench for carry_skip_adder: directed table, reset/hold sequences, random vectors.
module tb_carry_skip_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic         cin;
    logic         in_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_valid;
`ifdef CARRY_SKIP_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    carry_skip_adder #(.WIDTH(W), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
`ifdef CARRY_SKIP_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition and sign-rule overflow.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] ms, output logic mco, output logic mov);
        int unsigned total;
        total = int'(ma) + int'(mb) + int'(mc);
        ms  = total[W-1:0];
        mco = total[W];
        mov = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] es, input logic ec,
                           input logic eo, input logic ev);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_valid"}, out_valid, ev);
`ifdef CARRY_SKIP_OVF_EN
        chk({tag, "_ovf"}, ovf, eo);
`else
        if (eo === 1'bx) $display("unexpected x");
`endif
    endtask

    logic [W-1:0] exp_sum;
    logic         exp_cout, exp_ovf, exp_valid;
    logic [W-1:0] ms;
    logic         mco, mov;

    initial begin
        vecs[0] = '{8'hA6, 8'hF5, 1'b0, 8'h9B, 1'b1, 1'b0};
        vecs[1] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        step(); step();
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; in_valid = 1'b1;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b1);
            $display("vec%0d a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", i,
                     vecs[i].a, vecs[i].b, vecs[i].cin, sum, cout);
        end

        // Reset wins over a valid input in the same cycle.
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1; rst = 1'b1;
        step();
        chk_out("rst_over_valid", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_out("rst_release", 8'hFF, 1'b1, 1'b0, 1'b1);

        // Back-to-back results then hold with out_valid low.
        a = 8'h12; b = 8'h34; cin = 1'b0; step();
        chk_out("b2b0", 8'h46, 1'b0, 1'b0, 1'b1);
        a = 8'hC0; b = 8'h50; cin = 1'b1; step();
        chk_out("b2b1", 8'h11, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0; a = 8'h01; b = 8'h01; cin = 1'b0; step();
        chk_out("hold0", 8'h11, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("hold1", 8'h11, 1'b1, 1'b0, 1'b0);

        exp_sum = 8'h11; exp_cout = 1'b1; exp_ovf = 1'b0; exp_valid = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            in_valid = ($urandom_range(0, 7) != 0);
            if (i % 16 == 0) b = ~a;
            exp_valid = in_valid;
            if (in_valid) begin
                model(a, b, cin, ms, mco, mov);
                exp_sum = ms; exp_cout = mco; exp_ovf = mov;
            end
            step();
            chk_out("rand", exp_sum, exp_cout, exp_ovf, exp_valid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
